// File: rtl/sw_conditioner_pkg.sv
// Shared constants for the switch conditioner: per-channel state encodings
// and default debounce length / counter width.
package sw_conditioner_pkg;

  localparam logic [0:0] ST_STABLE   = 1'b0;
  localparam logic [0:0] ST_COUNTING = 1'b1;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int CNT_W_DEF           = 16;

endpackage

// File: rtl/debounce_ch.sv
// One switch channel: 2-flop synchronizer plus a tick-qualified debounce counter.
// Output follows raw DEBOUNCE_CYCLES+3 edges after a stable step (tick=1); no backpressure.
module debounce_ch
  import sw_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic upd
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [0:0]       state;
  logic [CNT_W-1:0] count;
  logic             differs;

  assign differs = (s2 != level);

  // Asserted on the edge at which level takes the synchronized value.
  assign upd = (state == ST_COUNTING) && differs && tick && (count == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_STABLE;
      count <= '0;
      level <= 1'b0;
    end else begin
      case (state)
        ST_STABLE: begin
          if (differs) begin
            state <= ST_COUNTING;
            count <= '0;
          end
        end
        default: begin
          if (!differs) begin
            // Input bounced back before qualifying: drop the attempt.
            state <= ST_STABLE;
            count <= '0;
          end else if (tick) begin
            if (count == CNT_LAST) begin
              level <= s2;
              count <= '0;
              state <= ST_STABLE;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/sw_conditioner.sv
// Debounces three asynchronous switch inputs (a, b, sel) and flags any output update.
// Latency DEBOUNCE_CYCLES+3 qualified edges per channel, changed one cycle pulse; no backpressure.
module sw_conditioner
  import sw_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic a_raw,
  input  logic b_raw,
  input  logic sel_raw,
  output logic a,
  output logic b,
  output logic sel,
  output logic changed
);

  logic [2:0] upd;

  debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .raw(a_raw), .level(a), .upd(upd[0])
  );

  debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .raw(b_raw), .level(b), .upd(upd[1])
  );

  debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_sel (
    .clk(clk), .rst_n(rst_n), .tick(tick), .raw(sel_raw), .level(sel), .upd(upd[2])
  );

  // Simultaneous channel updates merge into a single pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed <= 1'b0;
    end else begin
      changed <= |upd;
    end
  end

endmodule

// File: tb/tb_sw_conditioner.sv
// Randomized and directed bench for sw_conditioner (DEBOUNCE_CYCLES=4) against
// a behavioural model of the debounce rules.
module tb_sw_conditioner;

  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b1;
  logic a_raw = 1'b1, b_raw = 1'b1, sel_raw = 1'b1;
  logic a, b, sel, changed;

  int n_checks = 0;
  int n_fail   = 0;

  sw_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .a_raw(a_raw), .b_raw(b_raw), .sel_raw(sel_raw),
    .a(a), .b(b), .sel(sel), .changed(changed)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw is seen two edges late; the first edge that sees a
  // difference from the output arms the debounce, then DC qualified samples
  // with the difference still present move the output.
  bit m_s1[3], m_s2[3], m_out[3], m_armed[3];
  int m_held[3];
  bit m_chg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_out[c] = 0; m_armed[c] = 0; m_held[c] = 0;
      end
      m_chg = 0;
    end else begin
      bit any;
      bit raw_now[3];
      any = 0;
      raw_now[0] = a_raw; raw_now[1] = b_raw; raw_now[2] = sel_raw;
      for (int c = 0; c < 3; c++) begin
        if (m_s2[c] != m_out[c]) begin
          if (!m_armed[c]) begin
            m_armed[c] = 1;
            m_held[c]  = 0;
          end else if (tick) begin
            m_held[c]++;
            if (m_held[c] == DC) begin
              m_out[c]   = m_s2[c];
              m_armed[c] = 0;
              any        = 1;
            end
          end
        end else begin
          m_armed[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = raw_now[c];
      end
      m_chg = any;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    chk("model_a",       {31'd0, a},       {31'd0, m_out[0]});
    chk("model_b",       {31'd0, b},       {31'd0, m_out[1]});
    chk("model_sel",     {31'd0, sel},     {31'd0, m_out[2]});
    chk("model_changed", {31'd0, changed}, {31'd0, m_chg});
  end

  // Driver steps land 1 time unit after a falling edge.
  task automatic nxt(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset held with all raw inputs high.
    for (int i = 0; i < 10; i++) begin
      nxt(1);
      chk("rst_outs", {29'd0, a, b, sel}, 32'd0);
      chk("rst_changed", {31'd0, changed}, 32'd0);
    end
    rst_n = 1'b1;
    nxt(6);
    chk("rel_outs_e6", {29'd0, a, b, sel}, 32'd0);
    nxt(1);
    chk("rel_outs_e7", {29'd0, a, b, sel}, 32'd7);
    chk("rel_changed_e7", {31'd0, changed}, 32'd1);
    nxt(1);
    chk("rel_changed_e8", {31'd0, changed}, 32'd0);

    a_raw = 0; b_raw = 0; sel_raw = 0;
    nxt(12);
    chk("all_low", {29'd0, a, b, sel}, 32'd0);

    // Step on a.
    a_raw = 1;
    nxt(6);
    chk("step_a_e6", {31'd0, a}, 32'd0);
    nxt(1);
    chk("step_a_e7", {31'd0, a}, 32'd1);
    chk("step_changed_e7", {31'd0, changed}, 32'd1);
    chk("step_b_sel", {30'd0, b, sel}, 32'd0);
    nxt(1);
    chk("step_changed_e8", {31'd0, changed}, 32'd0);

    // Glitch on b: three clocks high.
    b_raw = 1;
    nxt(3);
    b_raw = 0;
    for (int i = 0; i < 10; i++) begin
      nxt(1);
      chk("glitch_b", {31'd0, b}, 32'd0);
      chk("glitch_changed", {31'd0, changed}, 32'd0);
    end

    // Tick gating: one qualified tick every fourth edge.
    tick = 0;
    sel_raw = 1;
    for (int k = 1; k <= 17; k++) begin
      tick = ((k % 4) == 0);
      nxt(1);
      if (k < 16) chk("tick_sel_early", {31'd0, sel}, 32'd0);
      if (k == 16) begin
        chk("tick_sel_rise", {31'd0, sel}, 32'd1);
        chk("tick_changed", {31'd0, changed}, 32'd1);
      end
    end
    tick = 1;

    // Reset in the middle of a count.
    a_raw = 0;
    nxt(12);
    chk("a_fell", {31'd0, a}, 32'd0);
    a_raw = 1;
    nxt(4);
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      nxt(1);
      chk("midrst_a", {31'd0, a}, 32'd0);
    end
    rst_n = 1;
    nxt(6);
    chk("midrst_rel_e6", {31'd0, a}, 32'd0);
    nxt(1);
    chk("midrst_rel_e7", {31'd0, a}, 32'd1);
    nxt(4);

    // Simultaneous change on a and sel.
    a_raw = 0; sel_raw = 0;
    nxt(6);
    chk("simul_e6", {30'd0, a, sel}, 32'd3);
    nxt(1);
    chk("simul_e7", {30'd0, a, sel}, 32'd0);
    chk("simul_changed_e7", {31'd0, changed}, 32'd1);
    nxt(1);
    chk("simul_changed_e8", {31'd0, changed}, 32'd0);

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) a_raw = ~a_raw;
      if ($urandom_range(0, 11) == 0) b_raw = ~b_raw;
      if ($urandom_range(0, 11) == 0) sel_raw = ~sel_raw;
      if ($urandom_range(0, 499) == 0) rst_n = 0;
      else if (!rst_n && $urandom_range(0, 1) == 0) rst_n = 1;
      nxt(1);
    end
    rst_n = 1;
    nxt(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_conditioner.md
SW_CONDITIONER -- requirements
Module: sw_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive qualified samples a changed input must hold before its output follows; legal range 1..65535.
REQ-002 SHALL have parameter CNT_W, default 16: debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port tick, input, 1 bit: sample-qualify strobe; tie to 1 to sample every clk.
REQ-006 SHALL have ports a_raw, b_raw, sel_raw, input, 1 bit each: asynchronous switch inputs.
REQ-007 SHALL have ports a, b, sel, output, 1 bit each, registered: debounced levels, directly feeding the downstream mux/or stage.
REQ-008 SHALL have port changed, output, 1 bit, registered: one-clk pulse on any update of a, b or sel.

Function
REQ-009 SHALL pass each raw input through a 2-flop synchronizer (s1, s2) clocked every clk, independent of tick.
REQ-010 SHALL run three identical, independent channels; no cross-channel coupling except the changed OR.
REQ-011 SHALL implement per channel states STABLE and COUNTING.
REQ-012 STABLE: when s2 != output, go to COUNTING with count=0 on that edge; otherwise hold.
REQ-013 COUNTING, tick=1, s2 != output: count increments; when count reaches DEBOUNCE_CYCLES-1 on a qualified sample, output takes s2, count clears, state returns to STABLE.
REQ-014 COUNTING, s2 == output (glitch): return to STABLE, count=0, output unchanged; evaluated every clk regardless of tick.
REQ-015 COUNTING, tick=0, s2 != output: count and output hold.
REQ-016 Count SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around.
REQ-017 With tick=1 continuously and a raw step held stable, output SHALL change exactly DEBOUNCE_CYCLES+3 rising edges after the first edge sampling the new raw level (2 sync + 1 entry + DEBOUNCE_CYCLES counting).
REQ-018 DEBOUNCE_CYCLES=1: output updates on the first qualified sample after entering COUNTING.
REQ-019 changed SHALL be 1 on the cycle after the edge at which any output updated, 0 otherwise; simultaneous updates on several channels give a single one-cycle pulse.
REQ-020 Raw pulses shorter than DEBOUNCE_CYCLES qualified samples SHALL never reach the outputs.

Reset
REQ-021 rst_n=0 SHALL immediately force s1, s2, count to 0, state to STABLE, a, b, sel, changed to 0, independent of clk.
REQ-022 Reset asserted mid-COUNTING SHALL abort the count; no pending update survives reset.
REQ-023 After rst_n deasserts, a raw input held at 1 SHALL propagate per REQ-017, as a 0->1 change.

Structure
REQ-024 State encodings (ST_STABLE=0, ST_COUNTING=1) and the default DEBOUNCE_CYCLES value SHALL live in the team's shared constants package/header.
REQ-025 The channel logic (synchronizer, state, counter) SHALL be one sub-module, debounce_ch, instantiated three times; sw_conditioner holds only instances and the changed register.
REQ-026 RTL SHALL be synthesizable, no latches, no combinational output paths.

Verification (DEBOUNCE_CYCLES=4, tick=1 unless stated)
REQ-027 Reset: rst_n=0 with a_raw=b_raw=sel_raw=1, run 10 clk -> a=b=sel=0, changed=0 throughout; release -> all three rise together exactly 7 edges later, with a single changed pulse.
REQ-028 Step: a_raw 0->1 held -> a rises exactly 7 edges after the first sampling edge; changed high exactly one cycle; b, sel unaffected.
REQ-029 Glitch: b_raw high for 3 clk then low -> b stays 0, changed stays 0.
REQ-030 Tick gating: tick high 1 of every 4 clk, sel_raw 0->1 held -> sel rises after exactly 4 qualified ticks in COUNTING; never sooner.
REQ-031 Reset mid-count: a_raw 0->1, assert rst_n after 4 edges -> a stays 0; after release, a rises per REQ-023.
REQ-032 Simultaneous: a_raw and sel_raw toggle on the same edge -> both outputs update on the same edge, one changed pulse.
